// File: rtl/pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pc_pkg : shared next-PC select encoding and link-register constants   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEL_TRAP   = 3'd0,
    PC_SEL_JALR   = 3'd1,
    PC_SEL_JAL    = 3'd2,
    PC_SEL_BRANCH = 3'd3,
    PC_SEL_SEQ    = 3'd4
  } pc_sel_e;

  localparam int PC_STEP = 4;

  // Link registers recognised by the decoder when classifying calls/returns
  localparam logic [4:0] RA_X1 = 5'd1;
  localparam logic [4:0] RA_X5 = 5'd5;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ras_stack : circular return-address stack with push/pop/swap/flush    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            valid,
  output logic            underflow
);

  localparam logic [RAS_PTR_W:0] c_full = (RAS_PTR_W+1)'(RAS_DEPTH);

  logic [XLEN-1:0]      r_entries [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_ptr;
  logic [RAS_PTR_W:0]   r_count;
  logic                 r_underflow;
  logic [RAS_PTR_W-1:0] w_top_idx;
  logic                 w_empty;

  assign w_top_idx = r_ptr - RAS_PTR_W'(1);
  assign w_empty   = (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      if (flush) begin
        r_count <= '0;
      end else if (push && pop && !w_empty) begin
        r_entries[w_top_idx] <= push_addr;
      end else if (push) begin
        // Full stack silently overwrites the oldest slot; pop here means empty
        r_entries[r_ptr] <= push_addr;
        r_ptr            <= r_ptr + RAS_PTR_W'(1);
        if (r_count != c_full)
          r_count <= r_count + (RAS_PTR_W+1)'(1);
        r_underflow <= pop;
      end else if (pop) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_ptr   <= w_top_idx;
          r_count <= r_count - (RAS_PTR_W+1)'(1);
        end
      end
    end
  end

  assign top       = w_empty ? '0 : r_entries[w_top_idx];
  assign valid     = !w_empty;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: rtl/pc_gen_ras.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pc_gen_ras : IF-stage next-PC generator with integrated return stack  |
// | Optional: PC_MISALIGN_CHECK_EN adds misaligned_fault output            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pc_gen_ras
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            ras_push,
  input  logic            ras_pop,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_flush,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ras_underflow
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misaligned_fault
`endif
);

  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  pc_sel_e         w_sel;
  logic            w_misaligned;

  assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

  always_comb begin
    w_sel = PC_SEL_SEQ;
    if (trap_valid)        w_sel = PC_SEL_TRAP;
    else if (jalr)         w_sel = PC_SEL_JALR;
    else if (jal)          w_sel = PC_SEL_JAL;
    else if (branch_taken) w_sel = PC_SEL_BRANCH;
  end

  always_comb begin
    case (w_sel)
      PC_SEL_TRAP:   w_next_pc = trap_target;
      PC_SEL_JALR:   w_next_pc = {jalr_target[XLEN-1:1], 1'b0};
      PC_SEL_JAL:    w_next_pc = jal_target;
      PC_SEL_BRANCH: w_next_pc = branch_target;
      default:       w_next_pc = w_pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic r_misaligned_fault;

  // Only an accepted non-trap redirect can fault; a stalled one is dropped anyway
  assign w_misaligned = pc_write && w_next_pc[1] &&
                        (w_sel == PC_SEL_JALR || w_sel == PC_SEL_JAL ||
                         w_sel == PC_SEL_BRANCH);

  always_ff @(posedge clk) begin
    if (reset) r_misaligned_fault <= 1'b0;
    else       r_misaligned_fault <= w_misaligned;
  end

  assign misaligned_fault = r_misaligned_fault;
`else
  assign w_misaligned = 1'b0;
`endif

  // Trap redirects bypass the stall
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_VECTOR;
    else if (w_sel == PC_SEL_TRAP)
      r_pc <= w_next_pc;
    else if (pc_write && !w_misaligned)
      r_pc <= w_next_pc;
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .valid     (ras_valid),
    .underflow (ras_underflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pc_gen_ras : scoreboard bench for pc_gen_ras (RAS_DEPTH = 4)        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b0;
  logic        trap_valid = 1'b0, jalr = 1'b0, jal = 1'b0, branch_taken = 1'b0;
  logic [31:0] trap_target = '0, jalr_target = '0, jal_target = '0, branch_target = '0;
  logic        ras_push = 1'b0, ras_pop = 1'b0, ras_flush = 1'b0;
  logic [31:0] ras_push_addr = '0;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, ras_underflow;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misaligned_fault;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] top;
    logic        uf;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_gen_ras #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_1000),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .jalr          (jalr),
    .jalr_target   (jalr_target),
    .jal           (jal),
    .jal_target    (jal_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ras_push      (ras_push),
    .ras_pop       (ras_pop),
    .ras_push_addr (ras_push_addr),
    .ras_flush     (ras_flush),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_top       (ras_top),
    .ras_valid     (ras_valid),
    .ras_underflow (ras_underflow)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misaligned_fault (misaligned_fault)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, req);
    end
  endtask

  // Monitor: compares the post-edge DUT state on the falling edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      chk({m.name, ".pc"}, pc, m.pc);
      chk({m.name, ".pc_plus4"}, pc_plus4, m.pc + 32'd4);
      chk({m.name, ".ras_valid"}, {31'd0, ras_valid}, {31'd0, m.valid});
      chk({m.name, ".ras_top"}, ras_top, m.top);
      chk({m.name, ".ras_underflow"}, {31'd0, ras_underflow}, {31'd0, m.uf});
`ifdef PC_MISALIGN_CHECK_EN
      chk({m.name, ".misaligned_fault"}, {31'd0, misaligned_fault}, {31'd0, m.fault});
`endif
    end
  end

  task automatic clr();
    trap_valid = 1'b0; jalr = 1'b0; jal = 1'b0; branch_taken = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0; ras_flush = 1'b0;
  endtask

  task automatic step(input string n, input logic [31:0] epc, input logic ev,
                      input logic [31:0] etop, input logic euf, input logic efault);
    exp_t e;
    @(posedge clk);
    e.name = n; e.pc = epc; e.valid = ev; e.top = etop; e.uf = euf; e.fault = efault;
    q.push_back(e);
    #1;
    clr();
  endtask

  initial begin
    // Reset beats a simultaneous redirect and push
    reset = 1'b1; pc_write = 1'b1; jal = 1'b1; jal_target = 32'h3000;
    ras_push = 1'b1; ras_push_addr = 32'h77;
    step("reset", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; pc_write = 1'b1;
    step("seq1", 32'h1004, 1'b0, 32'h0, 1'b0, 1'b0);
    step("seq2", 32'h1008, 1'b0, 32'h0, 1'b0, 1'b0);
    step("seq3", 32'h100C, 1'b0, 32'h0, 1'b0, 1'b0);

    jalr = 1'b1; jalr_target = 32'h2001; jal = 1'b1; jal_target = 32'h3000;
    branch_taken = 1'b1; branch_target = 32'h4000;
    step("prio_jalr", 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0);
    jal = 1'b1; branch_taken = 1'b1;
    step("prio_jal", 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0);
    pc_write = 1'b0; trap_valid = 1'b1; trap_target = 32'h8000; jal = 1'b1;
    step("trap_stall", 32'h8000, 1'b0, 32'h0, 1'b0, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h500;
    step("stall_drop", 32'h8000, 1'b0, 32'h0, 1'b0, 1'b0);
    pc_write = 1'b1;
    step("release", 32'h8004, 1'b0, 32'h0, 1'b0, 1'b0);

    pc_write = 1'b0; trap_valid = 1'b1; trap_target = 32'hFFFF_FFFC;
    step("trap_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    pc_write = 1'b1;
    step("wrap", 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);

    jal = 1'b1; jal_target = 32'h102;
`ifdef PC_MISALIGN_CHECK_EN
    step("misalign", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    pc_write = 1'b0;
    step("misalign_end", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`else
    step("misalign", 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
    pc_write = 1'b0;
    step("misalign_end", 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
`endif
    trap_valid = 1'b1; trap_target = 32'h8002; jal = 1'b1; jal_target = 32'h102;
    step("trap_unchecked", 32'h8002, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step("reset_stall", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Stack overflow wraps over the oldest entry (depth 4)
    ras_push = 1'b1; ras_push_addr = 32'h10;
    step("push10", 32'h1000, 1'b1, 32'h10, 1'b0, 1'b0);
    ras_push = 1'b1; ras_push_addr = 32'h20;
    step("push20", 32'h1000, 1'b1, 32'h20, 1'b0, 1'b0);
    ras_push = 1'b1; ras_push_addr = 32'h30;
    step("push30", 32'h1000, 1'b1, 32'h30, 1'b0, 1'b0);
    ras_push = 1'b1; ras_push_addr = 32'h40;
    step("push40", 32'h1000, 1'b1, 32'h40, 1'b0, 1'b0);
    ras_push = 1'b1; ras_push_addr = 32'h50;
    step("push50", 32'h1000, 1'b1, 32'h50, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop1", 32'h1000, 1'b1, 32'h40, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop2", 32'h1000, 1'b1, 32'h30, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop3", 32'h1000, 1'b1, 32'h20, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop4", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop5_uf", 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0);
    step("uf_clear", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);

    ras_push = 1'b1; ras_push_addr = 32'h100;
    step("push100", 32'h1000, 1'b1, 32'h100, 1'b0, 1'b0);
    ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h200;
    step("swap200", 32'h1000, 1'b1, 32'h200, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop_swap", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h300;
    step("swap_empty", 32'h1000, 1'b1, 32'h300, 1'b1, 1'b0);
    ras_flush = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h400;
    step("flush", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    ras_pop = 1'b1;
    step("pop_flushed", 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0);
    ras_push = 1'b1; ras_push_addr = 32'h500;
    step("push500", 32'h1000, 1'b1, 32'h500, 1'b0, 1'b0);

    reset = 1'b1; pc_write = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h600; jal = 1'b1;
    step("reset_push", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; pc_write = 1'b1;
    step("after_reset", 32'h1004, 1'b0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised next-generation program counter for the five-stage pipeline; sits in IF and drives the instruction-memory address.
- Selects the next PC from trap, jalr, jal, branch and sequential sources.
- Adds a configurable reset vector, a trap redirect that bypasses stall, and an integrated circular return-address stack (RAS).
- The RAS gives ID/EX a predicted return address; it is updated by call/return events resolved in EX.

Parameters:
- XLEN, 32, width of PC, targets and RAS entries.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- RAS_DEPTH, 8, number of RAS entries; power of two, >= 2.
- RAS_PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_write  in  1  1 = PC may advance; 0 = stall and hold PC (trap excepted).
- trap_valid  in  1  trap/exception redirect request.
- trap_target  in  XLEN  trap handler address.
- jalr  in  1  jalr redirect.
- jalr_target  in  XLEN  rs1+imm; bit 0 is cleared internally.
- jal  in  1  jal redirect.
- jal_target  in  XLEN  pc+imm.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  XLEN  branch destination.
- ras_push  in  1  call retired in EX (jal/jalr with rd = x1/x5).
- ras_pop  in  1  return retired in EX (jalr with rs1 = x1/x5, rd != rs1).
- ras_push_addr  in  XLEN  link address (call pc + 4).
- ras_flush  in  1  invalidate all RAS entries.
- pc  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN.
- ras_top  out  XLEN  predicted return address; 0 when ras_valid = 0.
- ras_valid  out  1  RAS non-empty.
- ras_underflow  out  1  one-cycle pulse: pop with pop-only, or push+pop, on empty stack.

Behaviour:
- Reset (synchronous, clk edge with reset = 1): pc = RESET_VECTOR; RAS ptr = 0, count = 0; ras_valid = 0, ras_top = 0, ras_underflow = 0. Reset beats every other input, including reset mid-stall or mid-push.
- Next-PC priority: trap_valid > jalr > jal > branch_taken > pc + 4. jalr path uses {jalr_target[XLEN-1:1], 1'b0}.
- trap_valid loads trap_target on the next edge even when pc_write = 0.
- Any other redirect with pc_write = 0 is dropped and PC holds. Re-presenting the redirect is the hazard unit's job.
- Latency: a redirect asserted in cycle N appears on pc in cycle N+1. pc_plus4 is combinational from pc.
- All PC arithmetic is XLEN-bit and wraps silently: pc = {XLEN{1'b1}} - 3 → next pc = 0.
- RAS storage: entries[RAS_DEPTH], ptr (next write slot), count (0..RAS_DEPTH). Top = entries[ptr-1] (modulo RAS_DEPTH).
- RAS updates are independent of pc_write; all are qualified each cycle by ras_flush first.
  - ras_flush: count = 0, ptr unchanged, push/pop ignored that cycle.
  - push only: entries[ptr] = ras_push_addr; ptr++; count = min(count+1, RAS_DEPTH). On full, the oldest entry is overwritten (wrap), with no error.
  - pop only: if count > 0, ptr--, count--. If count = 0, no state change and ras_underflow = 1 for one cycle.
  - push + pop (coroutine swap): if count > 0, entries[ptr-1] = ras_push_addr with ptr and count unchanged. If count = 0, behaves as push only and ras_underflow pulses.
- ras_top and ras_valid are registered-state derived, so a push is visible the cycle after the edge.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_fault (1 bit, registered, reset 0).
  - If the selected non-trap redirect target has bit 1 set, the PC holds and misaligned_fault pulses high for one cycle.
  - Trap targets are never checked.
- Undefined: port absent; misaligned targets are loaded as-is.

Decomposition:
- Shared package pc_pkg:
  - next-PC select enum (PC_SEL_TRAP, PC_SEL_JALR, PC_SEL_JAL, PC_SEL_BRANCH, PC_SEL_SEQ);
  - constant PC_STEP = 4;
  - link register indices RA_X1 = 1, RA_X5 = 5 (used by the decoder generating push/pop).
- One natural sub-module, ras_stack: the circular RAS with push/pop/flush/underflow, parametrised by XLEN and RAS_DEPTH.
- pc_gen_ras instantiates ras_stack plus the PC mux/register.

Test Plan:
- Reset with RESET_VECTOR = 32'h0000_1000, then 3 cycles pc_write = 1 → pc = 1000, 1004, 1008, 100C; ras_valid = 0.
- Same cycle: jalr target 0x2001, jal 0x3000, branch 0x4000 → pc = 0x2000 next cycle. Then trap_valid with target 0x8000 and pc_write = 0 → pc = 0x8000.
- pc_write = 0 with branch_taken target 0x500 → pc holds. Release with no redirect → pc = held + 4.
- RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_top = 0x50. Four pops give tops 0x40, 0x30, 0x20, then ras_valid = 0. Fifth pop → ras_underflow = 1 for one cycle.
- push 0x100, then push + pop with 0x200 → ras_top = 0x200 and count = 1. One pop → ras_valid = 0.
- pc = 0xFFFF_FFFC sequential → pc = 0. With PC_MISALIGN_CHECK_EN, jal_target 0x102 → pc holds, misaligned_fault pulses.
